// File: rtl/f2i_pkg.sv
// f2i_pkg: constants, result record and helper function shared by the
// float-to-int arbiter and its conversion pipeline.
//   F2I_BIAS / F2I_MANT_W / F2I_EXP_W : IEEE-754 single field constants
//   F2I_EXP_ZSH : exponent at which {1,m} needs no shift (bias + mantissa width)
//   F2I_EXP_OOR : first exponent whose magnitude no longer fits in 31 bits
//   f2i_result_t : one converted result (data, requester id, overflow flag)
package f2i_pkg;

  localparam int F2I_MANT_W = 23;
  localparam int F2I_EXP_W  = 8;
  localparam int F2I_ID_W   = 8;  // widest requester index a result record can carry

  localparam logic [F2I_EXP_W-1:0] F2I_BIAS    = 8'd127;
  localparam logic [F2I_EXP_W-1:0] F2I_EXP_ZSH = 8'd150;
  localparam logic [F2I_EXP_W-1:0] F2I_EXP_OOR = 8'd158;
  localparam logic [F2I_EXP_W-1:0] F2I_EXP_MAX = 8'd255;

  localparam logic [31:0] F2I_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] F2I_NEG_SAT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0]         data;
    logic [F2I_ID_W-1:0] id;
    logic                ovf;
  } f2i_result_t;

  // Two's-complement negate of a magnitude when the sign is set.
  function automatic logic [31:0] f2i_apply_sign(input logic neg, input logic [31:0] mag);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/f2i_core.sv
// f2i_core: two-stage float-to-int pipeline, no stall, id carried alongside.
//   Stage 1 registers the sign, {1,m}, id and the decoded exponent
//   (below-one flag, shift direction, shift amount).
//   Stage 2 registers the shifted, signed 32-bit result and the ovf flag.
// Ports: clk, rst (sync, active high), i_valid/i_data/i_id in,
//        o_valid/o_res out (o_res is an f2i_result_t).
// Optional build macro F2I_SAT_EN: saturate out-of-range/Inf/NaN inputs and
// raise ovf; without it the wrapped shift result is passed and ovf is 0.
module f2i_core
  import f2i_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [31:0]     i_data,
  input  logic [ID_W-1:0] i_id,
  output logic            o_valid,
  output f2i_result_t     o_res
);

  logic [F2I_EXP_W-1:0] w_exp;
  logic                 w_small;
  logic                 w_left;
  logic [F2I_EXP_W-1:0] w_shamt;

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [23:0]          r_s1_mant;
  logic                 r_s1_small;
  logic                 r_s1_left;
  logic [F2I_EXP_W-1:0] r_s1_shamt;
  logic [ID_W-1:0]      r_s1_id;

  logic [31:0]          w_mag;
  logic [31:0]          w_signed;
  logic [31:0]          w_res;
  logic                 w_ovf;

  logic                 r_s2_valid;
  logic [31:0]          r_s2_data;
  logic                 r_s2_ovf;
  logic [ID_W-1:0]      r_s2_id;

  assign w_exp   = i_data[30:23];
  assign w_small = (w_exp < F2I_BIAS);
  assign w_left  = (w_exp > F2I_EXP_ZSH);
  // Shift distance from the no-shift exponent, in whichever direction applies.
  assign w_shamt = w_left ? (w_exp - F2I_EXP_ZSH) : (F2I_EXP_ZSH - w_exp);

`ifdef F2I_SAT_EN
  logic w_oor;
  logic w_nan;
  logic r_s1_oor;
  logic r_s1_nan;

  // -2^31 (sign set, e=158, m=0) is the only e>=158 value that still fits.
  assign w_oor = (w_exp >= F2I_EXP_OOR) &&
                 !(i_data[31] && (w_exp == F2I_EXP_OOR) && (i_data[22:0] == 23'd0));
  assign w_nan = (w_exp == F2I_EXP_MAX) && (i_data[22:0] != 23'd0);

  // Stage-1 range flags for the saturation path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_oor <= 1'b0;
      r_s1_nan <= 1'b0;
    end else begin
      r_s1_oor <= w_oor;
      r_s1_nan <= w_nan;
    end
  end
`endif

  // Stage 1: capture operand, id and decoded exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mant  <= 24'd0;
      r_s1_small <= 1'b0;
      r_s1_left  <= 1'b0;
      r_s1_shamt <= 8'd0;
      r_s1_id    <= {ID_W{1'b0}};
    end else begin
      r_s1_valid <= i_valid;
      r_s1_sign  <= i_data[31];
      r_s1_mant  <= {1'b1, i_data[22:0]};
      r_s1_small <= w_small;
      r_s1_left  <= w_left;
      r_s1_shamt <= w_shamt;
      r_s1_id    <= i_id;
    end
  end

  // Magnitude: zero below 1.0, otherwise {1,m} shifted; left shifts of 32+ drop to zero.
  always_comb begin
    w_mag = 32'd0;
    if (r_s1_small) begin
      w_mag = 32'd0;
    end else if (r_s1_left) begin
      w_mag = {8'd0, r_s1_mant} << r_s1_shamt;
    end else begin
      w_mag = {8'd0, r_s1_mant} >> r_s1_shamt;
    end
  end

  assign w_signed = f2i_apply_sign(r_s1_sign, w_mag);

  // Final value and overflow flag.
  always_comb begin
    w_res = w_signed;
    w_ovf = 1'b0;
`ifdef F2I_SAT_EN
    if (r_s1_oor) begin
      w_res = (r_s1_nan || !r_s1_sign) ? F2I_POS_SAT : F2I_NEG_SAT;
      w_ovf = 1'b1;
    end else begin
      w_res = w_signed;
      w_ovf = 1'b0;
    end
`endif
  end

  // Stage 2: converted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= 32'd0;
      r_s2_ovf   <= 1'b0;
      r_s2_id    <= {ID_W{1'b0}};
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_res;
      r_s2_ovf   <= w_ovf;
      r_s2_id    <= r_s1_id;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_res   = '{data: r_s2_data, id: F2I_ID_W'(r_s2_id), ovf: r_s2_ovf};

endmodule

// File: rtl/f2i_arbiter.sv
// f2i_arbiter: round-robin sharing of one f2i_core among NUM_REQ requesters,
// with a credit counter guarding a DEPTH-entry result FIFO.
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   req_valid/req_data    per-requester float (lane i = bits [32i+31:32i])
//   req_ready             one-hot (or zero) accept, combinational, 0 during rst
//   res_valid/res_ready   shared result handshake
//   res_data/res_id/res_ovf  integer result, requester index, overflow flag
// Optional build macro F2I_SAT_EN (see f2i_core) selects saturating results.
module f2i_arbiter
  import f2i_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_used;     // accepted and not yet popped: pipeline + FIFO
  logic [CNT_W-1:0] r_count;    // FIFO occupancy
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  f2i_result_t      r_mem [DEPTH];

  logic [ID_W-1:0]  w_idx;
  logic             w_hit;
  logic             w_found;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_issue_ok;
  logic             w_accept;
  logic [31:0]      w_sel_data;
  logic             w_pop;
  logic             w_core_valid;
  f2i_result_t      w_core_res;

  // Credit > 0 exactly when fewer than DEPTH results are outstanding.
  assign w_issue_ok = (r_used < DEPTH_CNT);

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_idx     = {ID_W{1'b0}};
    w_hit     = 1'b0;
    w_found   = 1'b0;
    w_gnt_idx = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx     = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      w_hit     = !w_found && req_valid[w_idx];
      w_gnt_idx = w_hit ? w_idx : w_gnt_idx;
      w_found   = w_found | w_hit;
    end
  end

  assign w_accept = w_found && w_issue_ok && !rst;

  // One-hot ready and the matching data lane.
  always_comb begin
    req_ready  = {NUM_REQ{1'b0}};
    w_sel_data = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = w_accept && (w_gnt_idx == ID_W'(k));
      w_sel_data   = (w_gnt_idx == ID_W'(k)) ? req_data[32*k +: 32] : w_sel_data;
    end
  end

  // Round-robin pointer: moves past the granted requester only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {ID_W{1'b0}};
    end else if (w_accept) begin
      r_ptr <= (w_gnt_idx == LAST_ID) ? {ID_W{1'b0}} : (w_gnt_idx + ID_W'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  f2i_core #(
    .ID_W(ID_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_accept),
    .i_data (w_sel_data),
    .i_id   (w_gnt_idx),
    .o_valid(w_core_valid),
    .o_res  (w_core_res)
  );

  // Outstanding-result counter backing the credit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_used <= {CNT_W{1'b0}};
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_used <= r_used + CNT_W'(1);
        2'b01:   r_used <= r_used - CNT_W'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // FIFO storage; credits guarantee a free slot for every push.
  always_ff @(posedge clk) begin
    if (w_core_valid) begin
      r_mem[r_wr_ptr] <= w_core_res;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_wr_ptr <= w_core_valid ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
      case ({w_core_valid, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result channel shows the FIFO head; fields read as zero while empty.
  always_comb begin
    res_valid = 1'b0;
    res_data  = 32'd0;
    res_id    = {ID_W{1'b0}};
    res_ovf   = 1'b0;
    if (r_count != {CNT_W{1'b0}}) begin
      res_valid = 1'b1;
      res_data  = r_mem[r_rd_ptr].data;
      res_id    = ID_W'(r_mem[r_rd_ptr].id);
      res_ovf   = r_mem[r_rd_ptr].ovf;
    end else begin
      res_valid = 1'b0;
      res_data  = 32'd0;
      res_id    = {ID_W{1'b0}};
      res_ovf   = 1'b0;
    end
  end

  assign w_pop = res_valid && res_ready;

endmodule

// File: tb/tb_f2i_arbiter.sv
// Self-checking bench for f2i_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_f2i_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ovf;

  always #5 clk = ~clk;

  f2i_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rr       = 0;
  int last_gnt = -1;

  typedef struct { logic [31:0] data; int id; logic ovf; int avail; } exp_t;
  exp_t mq[$];   // every accepted, not yet popped result, in acceptance order

  typedef struct { logic [31:0] f; logic [31:0] d; logic ovf; } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Conversion from the numeric value: truncate toward zero, wrap modulo 2^32.
  function automatic void ref_conv(input logic [31:0] f, output logic [31:0] d, output logic ovf);
    int     e;
    logic   s;
    logic   nan;
    logic   oor;
    real    mag;
    real    wrapped;
    longint w;
    s   = f[31];
    e   = int'(f[30:23]);
    nan = (e == 255) && (f[22:0] != 23'd0);
    if (e == 255) begin
      wrapped = 0.0;   // infinite magnitude: no mantissa bit lands in the low 32
      oor     = 1'b1;
    end else begin
      mag     = $floor((8388608.0 + real'(f[22:0])) * (2.0 ** (e - 150)));
      wrapped = mag - $floor(mag / 4294967296.0) * 4294967296.0;
      oor     = s ? (mag > 2147483648.0) : (mag >= 2147483648.0);
    end
    w = longint'(wrapped);
    d = s ? (32'd0 - w[31:0]) : w[31:0];
    ovf = 1'b0;
`ifdef F2I_SAT_EN
    if (oor) begin
      d   = (nan || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      ovf = 1'b1;
    end
`endif
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic tick();
    logic [NUM_REQ-1:0] er;
    int    gi;
    logic  ev;
    exp_t  ne;
    logic [31:0] cd;
    logic  co;
    #3;
    er = '0;
    gi = -1;
    if (!rst && mq.size() < DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (gi < 0 && req_valid[(rr + k) % NUM_REQ]) gi = (rr + k) % NUM_REQ;
    end
    if (gi >= 0) er[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    ev = (mq.size() > 0) && (mq[0].avail <= cyc);
    chk("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      chk("res_data", res_data, mq[0].data);
      chk("res_id", 32'(res_id), 32'(mq[0].id));
      chk("res_ovf", 32'(res_ovf), 32'(mq[0].ovf));
    end
    last_gnt = gi;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      rr = 0;
    end else begin
      if (ev && res_ready) void'(mq.pop_front());
      if (gi >= 0) begin
        ref_conv(req_data[32*gi +: 32], cd, co);
        ne.data = cd; ne.id = gi; ne.ovf = co; ne.avail = cyc + 3;
        mq.push_back(ne);
        rr = (gi + 1) % NUM_REQ;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int sel = $urandom_range(0, 9);
    if (sel < 6)       e = 8'($urandom_range(120, 160));
    else if (sel < 8)  e = 8'($urandom_range(0, 255));
    else if (sel == 8) e = 8'd255;
    else               e = 8'd158;
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  vec_t vt[15];
  int   rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int   acc;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0};   // 1.0
    vt[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0};   // -2.5
    vt[2]  = '{32'h3F40_0000, 32'h0000_0000, 1'b0};   // 0.75
    vt[3]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0};   // -2^31
    vt[4]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};   // largest below 2^31
    vt[5]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};   // denormal
    vt[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};   // -0
    vt[7]  = '{32'hBF7F_FFFF, 32'h0000_0000, 1'b0};   // just above -1
    vt[8]  = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0};   // e=150, no shift
    vt[9]  = '{32'hCB00_0001, 32'hFF7F_FFFF, 1'b0};   // -8388609
`ifdef F2I_SAT_EN
    vt[10] = '{32'h4F32_D05E, 32'h7FFF_FFFF, 1'b1};   // 3e9
    vt[11] = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1};   // NaN
    vt[12] = '{32'hFF80_0000, 32'h8000_0000, 1'b1};   // -Inf
    vt[13] = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1};   // +2^31
    vt[14] = '{32'hCF00_0001, 32'h8000_0000, 1'b1};   // just below -2^31
`else
    vt[10] = '{32'h4F32_D05E, 32'hB2D0_5E00, 1'b0};
    vt[11] = '{32'h7FC0_0000, 32'h0000_0000, 1'b0};
    vt[12] = '{32'hFF80_0000, 32'h0000_0000, 1'b0};
    vt[13] = '{32'h4F00_0000, 32'h8000_0000, 1'b0};
    vt[14] = '{32'hCF00_0001, 32'h7FFF_FF00, 1'b0};
`endif

    // Reset state, with every requester asking.
    rst = 1'b1; req_valid = '1; req_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;

    // Vector table through requester 0, one at a time: 2-cycle latency.
    res_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      req_valid = 4'b0001; req_data = '0; req_data[31:0] = vt[i].f;
      #3;
      chk("tbl_accept", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      tick();
      tick();
      #3;
      chk("tbl_valid", 32'(res_valid), 32'd1);
      chk("tbl_data", res_data, vt[i].d);
      chk("tbl_ovf", 32'(res_ovf), 32'(vt[i].ovf));
      chk("tbl_id", 32'(res_id), 32'd0);
      tick();
    end

    // Round robin with everyone valid.
    do_reset();
    res_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = 32'h3F80_0000 + 32'(i << 20);
      #3;
      chk("rr_grant", 32'(req_ready), 32'(1) << rr_exp[i]);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Backpressure: exactly DEPTH accepts, resume the cycle after the first pop.
    do_reset();
    res_ready = 1'b0; req_valid = 4'b0010; acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_data[63:32] = {1'b0, 8'd130, 23'(i << 16)};
      #3;
      if ((req_ready & req_valid) != '0) acc++;
      tick();
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    #3;
    chk("bp_blocked", 32'(req_ready), 32'd0);
    res_ready = 1'b1;
    tick();
    #3;
    chk("bp_resume", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (10) tick();

    // Reset with two results in flight and two queued.
    do_reset();
    res_ready = 1'b0; req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req_data[31:0] = {1'b0, 8'd128, 23'(i << 18)};
      tick();
    end
    rst = 1'b1;
    #3;
    chk("rst_hold_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    #3;
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd0);
    tick();
    res_ready = 1'b1; req_valid = 4'b0100; req_data[95:64] = 32'h3F80_0000;
    tick();
    req_valid = '0;
    tick();
    tick();
    #3;
    chk("post_rst_res", 32'(res_valid), 32'd1);
    chk("post_rst_id", 32'(res_id), 32'd2);
    chk("post_rst_data", res_data, 32'd1);
    repeat (5) tick();

    // Randomized traffic with bursty backpressure and occasional reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = NUM_REQ'($urandom);
      if ((i / 50) % 2 == 1) res_ready = ($urandom_range(0, 4) == 0);
      else                   res_ready = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = rand_float();
      tick();
    end
    rst = 1'b0; req_valid = '0; res_ready = 1'b1;
    repeat (12) tick();
    chk("drain_empty", 32'(mq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f2i_arbiter.md
# f2i_arbiter

Shares one pipelined float-to-int conversion unit among `NUM_REQ` requesters. Arbitration is round-robin with valid/ready handshakes, and credits are tracked against a result FIFO. Each accepted IEEE-754 single is converted to a 32-bit two's-complement integer, truncating toward zero. The result is returned on one shared output channel, tagged with the requester index. The block sits between the scalar producers and the integer datapath.

## Interface

Parameters:

- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DEPTH`, default 4: result FIFO entries, power of two, ≥2.

Ports:

- `clk` input, 1: single clock; all logic is rising-edge.
- `rst` input, 1: synchronous, active-high reset.
- `req_valid` input, `NUM_REQ`: per-requester request valid.
- `req_data` input, `NUM_REQ*32`: per-requester float; requester i uses bits [32i+31:32i].
- `req_ready` output, `NUM_REQ`: per-requester accept, one-hot or zero.
- `res_valid` output, 1: result available.
- `res_ready` input, 1: consumer accepts result.
- `res_data` output, 32: integer result.
- `res_id` output, `$clog2(NUM_REQ)`: index of the originating requester.
- `res_ovf` output, 1: out-of-range, Inf or NaN flag.

## Operation

- Credit = `DEPTH` − FIFO occupancy − in-flight pipeline entries. Issue is allowed only when credit > 0.
- Grant:
  - When issue is allowed, `req_ready` is asserted combinationally to the first valid requester at or after the round-robin pointer.
  - A transfer occurs on `req_valid[i] & req_ready[i]`.
  - The pointer then moves to i+1 mod `NUM_REQ`.
  - The pointer does not move on cycles without a transfer.
- At most one accept per cycle. `req_ready` never depends on `res_ready`.
- Conversion, with e = exponent, m = mantissa, s = sign:
  - e < 127: result 0, ovf 0. This covers zero, denormals and |x| < 1.
  - 127 ≤ e ≤ 150: magnitude = {1,m} >> (150−e).
  - e > 150: magnitude = {1,m} << (e−150), keeping the low 32 bits.
  - s = 1: result = two's-complement negate of the magnitude.
  - Out of range when e ≥ 158, except s=1, e=158, m=0, which is −2^31 and in range. e = 255 (Inf/NaN) is always out of range.
- FIFO:
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - The FIFO cannot overflow, by construction through credits.
- Reset: pointer to 0, FIFO emptied, pipeline valids cleared, all in-flight and queued results discarded.
- Reset values of outputs: `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_ovf`=0. `req_ready` is forced to 0 while `rst` is high.

## Timing

- Conversion pipeline, two register stages:
  - Stage 1 captures the data, id and decoded exponent.
  - Stage 2 holds the shifted, signed result and ovf.
- A result pushes into the FIFO on the edge after stage 2.
- Latency: request accepted at edge T → `res_valid` high after edge T+2, when the FIFO was empty and no results are ahead of it.
- Throughput: one conversion per cycle when `res_ready` is held high.
- Ordering: results leave in acceptance order.
- Output hold: while `res_valid` is high and `res_ready` is low, `res_data`, `res_id` and `res_ovf` hold stable.
- Backpressure: with `res_ready` low, at most `DEPTH` further requests are accepted, then `req_ready` stays 0. Once a pop frees a credit, `req_ready` may reassert the next cycle.

## Configuration

- `F2I_SAT_EN` defined:
  - Out-of-range results saturate: s=0 or NaN → 0x7FFFFFFF; s=1 and not NaN → 0x80000000.
  - `res_ovf` = 1 for these results.
- `F2I_SAT_EN` undefined:
  - Out-of-range results take the wrapped value from the shift rule above, negated if s=1.
  - `res_ovf` is tied to 0.
  - The saturation and NaN detection logic is not compiled.

## Structure

- Shared package `f2i_pkg`:
  - Constants `F2I_BIAS`=127, `F2I_MANT_W`=23, `F2I_EXP_W`=8.
  - `f2i_result_t` struct: data, id, ovf.
  - Saturation constants `F2I_POS_SAT`, `F2I_NEG_SAT`.
- Sub-module `f2i_core`: the two-stage conversion pipeline, with valid in/out, no stall, and the id carried alongside the data.
- Arbiter, credit counter and FIFO live in `f2i_arbiter`.

## Test plan

- Req0 sends 0x3F800000 (1.0), then 0xC0200000 (−2.5), then 0x3F400000 (0.75) → results 0x00000001, 0xFFFFFFFE, 0x00000000, all id 0, ovf 0, first result 2 cycles after accept.
- All 4 requesters hold valid, `res_ready`=1 → grants 0,1,2,3,0,1; `res_id` follows the same order.
- `res_ready`=0, req1 continuously valid → exactly 4 accepts, then `req_ready`=0. Raise `res_ready` → 4 results drain in order, and accepts resume the cycle after the first pop.
- 0x4F32D05E (3e9) with `F2I_SAT_EN` → 0x7FFFFFFF, ovf 1. Without it → 0xB2D05E00, ovf 0.
- 0xCF000000 (−2^31) → 0x80000000, ovf 0. 0x7FC00000 (NaN) with `F2I_SAT_EN` → 0x7FFFFFFF, ovf 1.
- Assert `rst` with 2 results in flight and 2 in the FIFO → the next cycle has `res_valid`=0 and `req_ready`=0. After release, req2 sends 1.0 → only that result emerges, id 2.
